i2s_rx_master: RTL and testbench
================================

Name: i2s_rx_master

Overview:
Parametrised I2S master receiver, the successor to the fixed 16-bit receiver. Generates sclk_o and wsel_o from clk_i through an integer divider. Captures one word per channel slot in Philips I2S or left-justified framing, with slot width independent of word width. Delivers tagged samples over a valid/ready interface with sticky overflow reporting.

Parameters:
WORD_WIDTH, 16, sample bits captured per channel slot
SLOT_WIDTH, 32, sclk periods per channel slot; must be >= WORD_WIDTH + (LJ_MODE ? 0 : 1), elaboration error otherwise
CLK_DIV, 4, clk_i cycles per sclk period; even, >= 2
LJ_MODE, 0, 0 = Philips I2S (MSB one sclk after WS edge), 1 = left-justified (MSB on first sclk of slot)

Ports:
clk_i  in  1  system clock, sole clock domain
rst_i  in  1  reset, synchronous, active-high
en_i  in  1  run enable for serial clocking and capture
sdat_i  in  1  serial data from codec
sclk_o  out  1  bit clock, registered
wsel_o  out  1  word select, registered; 0 = left, 1 = right
data_o  out  WORD_WIDTH  captured sample, MSB first on the wire
lr_chnl_o  out  1  channel of data_o; 0 = left, 1 = right
valid_o  out  1  data_o/lr_chnl_o hold a sample
ready_i  in  1  consumer accepts; transfer when valid_o && ready_i
ovf_o  out  1  sticky: a completed word was dropped
ovf_clr_i  in  1  clears ovf_o

Behaviour:
- Reset, synchronous: sclk_o=0, wsel_o=0, data_o=0, lr_chnl_o=0, valid_o=0, ovf_o=0. Divider, slot counter and shift register are cleared.
- Divider: div_cnt runs 0..CLK_DIV-1.
  - sclk_o goes high at the edge where div_cnt leaves CLK_DIV/2-1 (rise strobe).
  - sclk_o goes low at the edge where div_cnt wraps (fall strobe).
- Sampling: sdat_i is shifted in at the rise-strobe edge, the same edge that raises sclk_o.
- Slot counter: bit_pos runs 0..SLOT_WIDTH-1 and advances on the fall strobe. On wrap, wsel_o toggles on that same edge.
- Capture window, by bit_pos at the sampling edge:
  - LJ: 0..WORD_WIDTH-1.
  - I2S: 1..WORD_WIDTH.
  - Bits outside the window are ignored.
- Word completion: occurs at the edge sampling the LSB.
  - data_o is loaded with the full word and lr_chnl_o with the current wsel_o.
  - valid_o=1 from the next clk_i cycle (1-cycle latency).
- Handshake:
  - data_o and lr_chnl_o are stable while valid_o=1 && !ready_i.
  - On transfer with no completion in that cycle: valid_o=0 next cycle.
  - Completion while valid_o=1 && !ready_i: the new word is dropped, the held word is kept, ovf_o=1.
  - Completion in the same cycle as a transfer: the new word is loaded, valid_o stays 1, no overflow.
- ovf_o is sticky and cleared by ovf_clr_i. Simultaneous set and clear: set wins.
- en_i=0:
  - div_cnt, bit_pos and the shift register are held at 0; sclk_o=0 and wsel_o=0.
  - A partial word is discarded.
  - The output register, valid_o and ovf_o keep operating, so a pending word can still drain.
- en_i 0->1: the first frame starts with the left slot, bit_pos=0, first rising sclk CLK_DIV/2 cycles later.
- rst_i mid-word: everything is cleared immediately; no valid is produced for the partial word.
- Only one output register is needed: completions are at least SLOT_WIDTH*CLK_DIV cycles apart.

Decomposition:
- Shared header (alongside the existing CLOG2 macro): channel constants CH_LEFT=0 and CH_RIGHT=1, and framing constants MODE_I2S=0 and MODE_LJ=1.
- Counter widths use CLOG2(CLK_DIV) and CLOG2(SLOT_WIDTH).
- Sub-module i2s_clk_gen: divider, sclk_o, rise/fall strobes, bit_pos, wsel_o, en_i gating. It is reused by the planned transmitter.

Test Plan:
Common config unless stated: WORD_WIDTH=16, SLOT_WIDTH=32, CLK_DIV=4, LJ_MODE=0.
1. rst_i high 3 cycles with en_i=0 -> all outputs 0; sclk_o stays 0 for 100 cycles.
2. en_i=1, codec model sends L=0xA5C3, R=0x1234, ready_i=1 -> sclk period 4 clk and wsel period 256 clk. Outputs: valid pulse with 0xA5C3/lr=0, then 0x1234/lr=1. Each valid pulse comes 1 cycle after its LSB sample.
3. LJ_MODE=1 instance, model sends LJ framing with the same words -> identical outputs. I2S-framed 0x8001 fed to this instance -> 0x4000 captured (one-bit misalignment detected).
4. ready_i=0 across 3 completions -> data_o holds 0xA5C3 and ovf_o=1 after the second completion. ready_i=1 -> one transfer, valid_o drops. ovf_o stays 1 until a ovf_clr_i pulse.
5. ready_i asserted exactly in the completion cycle while valid_o=1 -> transfer plus new word 0x1234 loaded, ovf_o stays 0. ovf_clr_i in the same cycle as an overflow -> ovf_o=1.
6. en_i dropped at bit_pos=8 of the left slot -> no valid, sclk_o=0, wsel_o=0. Re-enable -> next left word 0xA5C3 correct. Repeat with rst_i pulse mid-word -> same result, ovf_o=0.

Source files
------------

// File: rtl/i2s_rx_master_pkg.sv
// Shared constants and helpers for the I2S receive/transmit family.
// No logic; channel/framing encodings and counter sizing only.
// Imported by the clock generator and the receiver.
package i2s_rx_master_pkg;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  localparam int MODE_I2S = 0;
  localparam int MODE_LJ  = 1;

  // Counter width for a 0..v-1 counter, never narrower than one bit.
  function automatic int clog2(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// Bit/word clock generator: divides clk_i into sclk_o, tracks slot position, toggles wsel_o.
// Latency: strobes are combinational from div_cnt; sclk_o/wsel_o/bit_pos update on the strobe edge.
// Backpressure: none; en_i=0 parks every counter and output at zero.
module i2s_clk_gen
  import i2s_rx_master_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int SLOT_WIDTH = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         en_i,
  output logic                         sclk_o,
  output logic                         wsel_o,
  output logic                         rise_stb,
  output logic                         fall_stb,
  output logic [clog2(SLOT_WIDTH)-1:0] bit_pos
);

  localparam int DW = clog2(CLK_DIV);
  localparam int PW = clog2(SLOT_WIDTH);
  localparam logic [DW-1:0] RISE_CNT = DW'(CLK_DIV / 2 - 1);
  localparam logic [DW-1:0] LAST_CNT = DW'(CLK_DIV - 1);
  localparam logic [PW-1:0] LAST_POS = PW'(SLOT_WIDTH - 1);

  logic [DW-1:0] div_cnt;

  assign rise_stb = en_i && (div_cnt == RISE_CNT);
  assign fall_stb = en_i && (div_cnt == LAST_CNT);

  always_ff @(posedge clk_i) begin
    if (rst_i || !en_i) begin
      div_cnt <= '0;
      sclk_o  <= 1'b0;
      bit_pos <= '0;
      wsel_o  <= CH_LEFT;
    end else begin
      div_cnt <= fall_stb ? '0 : div_cnt + 1'b1;
      if (rise_stb) begin
        sclk_o <= 1'b1;
      end else if (fall_stb) begin
        sclk_o <= 1'b0;
      end
      // Slot boundary and word-select change share the falling sclk edge.
      if (fall_stb) begin
        if (bit_pos == LAST_POS) begin
          bit_pos <= '0;
          wsel_o  <= ~wsel_o;
        end else begin
          bit_pos <= bit_pos + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/i2s_rx_master.sv
// I2S master receiver: drives sclk/wsel, captures one word per slot, presents it on valid/ready.
// Latency: valid_o rises one clk_i cycle after the edge that samples the word's LSB.
// Backpressure: single output register; a word completing while one is held is dropped and ovf_o sets.
module i2s_rx_master
  import i2s_rx_master_pkg::*;
#(
  parameter int WORD_WIDTH = 16,
  parameter int SLOT_WIDTH = 32,
  parameter int CLK_DIV    = 4,
  parameter int LJ_MODE    = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  sdat_i,
  output logic                  sclk_o,
  output logic                  wsel_o,
  output logic [WORD_WIDTH-1:0] data_o,
  output logic                  lr_chnl_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  ovf_o,
  input  logic                  ovf_clr_i
);

  localparam int PW = clog2(SLOT_WIDTH);
  localparam int LEAD = (LJ_MODE == MODE_LJ) ? 0 : 1;
  localparam logic [PW-1:0] LSB_POS = PW'(WORD_WIDTH - 1 + LEAD);

  if (CLK_DIV < 2 || (CLK_DIV % 2) != 0) begin : g_bad_div
    $error("CLK_DIV must be even and at least 2");
  end
  if (SLOT_WIDTH < WORD_WIDTH + LEAD) begin : g_bad_slot
    $error("SLOT_WIDTH too small for WORD_WIDTH in this framing");
  end
  if (WORD_WIDTH < 2) begin : g_bad_word
    $error("WORD_WIDTH must be at least 2");
  end

  logic                  rise_stb;
  logic                  fall_stb_unused;
  logic [PW-1:0]         bit_pos;
  logic [WORD_WIDTH-1:0] shreg;
  logic [WORD_WIDTH-1:0] word;
  logic                  complete;
  logic                  xfer;

  i2s_clk_gen #(
    .CLK_DIV    (CLK_DIV),
    .SLOT_WIDTH (SLOT_WIDTH)
  ) u_clk_gen (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .en_i     (en_i),
    .sclk_o   (sclk_o),
    .wsel_o   (wsel_o),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb_unused),
    .bit_pos  (bit_pos)
  );

  // Shift on every rising strobe; at the LSB position the last WORD_WIDTH
  // bits are exactly the capture window, so out-of-window bits fall away.
  assign word     = {shreg[WORD_WIDTH-2:0], sdat_i};
  assign complete = rise_stb && (bit_pos == LSB_POS);
  assign xfer     = valid_o && ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i || !en_i) begin
      shreg <= '0;
    end else if (rise_stb) begin
      shreg <= word;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_o    <= '0;
      lr_chnl_o <= CH_LEFT;
      valid_o   <= 1'b0;
      ovf_o     <= 1'b0;
    end else begin
      if (complete && (!valid_o || ready_i)) begin
        data_o    <= word;
        lr_chnl_o <= wsel_o;
        valid_o   <= 1'b1;
      end else if (xfer) begin
        valid_o <= 1'b0;
      end
      if (complete && valid_o && !ready_i) begin
        ovf_o <= 1'b1;
      end else if (ovf_clr_i) begin
        ovf_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx_master.sv
// Directed bench: an I2S and a left-justified receiver, each fed by a codec model
// that follows the DUT's sclk/wsel pins.
module tb_i2s_rx_master;

  logic clk_i = 1'b0;
  logic rst, en, rdy, clr;
  logic sdat_a, sdat_b;
  logic sclk_a, wsel_a, lr_a, valid_a, ovf_a;
  logic sclk_b, wsel_b, lr_b, valid_b, ovf_b;
  logic [15:0] data_a, data_b;

  logic [15:0] a_l, a_r, b_l, b_r;
  bit b_i2s;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    int          cyc;
    logic [15:0] d;
    logic        lr;
  } xfer_t;
  xfer_t qa[$];
  xfer_t qb[$];

  always #5 clk_i = ~clk_i;

  i2s_rx_master #(.WORD_WIDTH(16), .SLOT_WIDTH(32), .CLK_DIV(4), .LJ_MODE(0)) dut_a (
    .clk_i(clk_i), .rst_i(rst), .en_i(en), .sdat_i(sdat_a), .sclk_o(sclk_a), .wsel_o(wsel_a),
    .data_o(data_a), .lr_chnl_o(lr_a), .valid_o(valid_a), .ready_i(rdy), .ovf_o(ovf_a),
    .ovf_clr_i(clr));

  i2s_rx_master #(.WORD_WIDTH(16), .SLOT_WIDTH(32), .CLK_DIV(4), .LJ_MODE(1)) dut_b (
    .clk_i(clk_i), .rst_i(rst), .en_i(en), .sdat_i(sdat_b), .sclk_o(sclk_b), .wsel_o(wsel_b),
    .data_o(data_b), .lr_chnl_o(lr_b), .valid_o(valid_b), .ready_i(rdy), .ovf_o(ovf_b),
    .ovf_clr_i(clr));

  // Bit placed on the wire at slot position p: Philips puts the MSB at p=1, LJ at p=0.
  function automatic logic bit_at(input logic [15:0] w, input int p, input bit lj);
    int idx;
    idx = lj ? 15 - p : 16 - p;
    return (idx >= 0 && idx <= 15) ? w[idx] : 1'b0;
  endfunction

  // Codec models: advance on each observed sclk fall, restart position on a wsel change.
  int  a_pos, b_pos;
  logic a_ws, b_ws, a_ps, b_ps;
  always @(negedge clk_i) begin
    if (rst || !en) begin
      a_pos = 0; a_ws = 1'b0;
    end else if (a_ps && !sclk_a) begin
      if (wsel_a != a_ws) begin a_ws = wsel_a; a_pos = 0; end
      else a_pos++;
    end
    a_ps   = sclk_a;
    sdat_a = bit_at(a_ws ? a_r : a_l, a_pos, 1'b0);
  end
  always @(negedge clk_i) begin
    if (rst || !en) begin
      b_pos = 0; b_ws = 1'b0;
    end else if (b_ps && !sclk_b) begin
      if (wsel_b != b_ws) begin b_ws = wsel_b; b_pos = 0; end
      else b_pos++;
    end
    b_ps   = sclk_b;
    sdat_b = bit_at(b_ws ? b_r : b_l, b_pos, !b_i2s);
  end

  // Transfer monitor: values read before the edge are what the DUT acts on.
  always @(posedge clk_i) begin
    cyc++;
    if (valid_a && rdy) qa.push_back('{cyc, data_a, lr_a});
    if (valid_b && rdy) qb.push_back('{cyc, data_b, lr_b});
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic run_to(input int target);
    int guard;
    guard = 0;
    while (cyc < target && guard < 5000) begin
      tick();
      guard++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int c0, highs, r1, r2, wr, wr2, wf;
  logic ps, pw;

  initial begin
    rst = 1'b1; en = 1'b0; rdy = 1'b1; clr = 1'b0;
    a_l = 16'hA5C3; a_r = 16'h1234; b_l = 16'hA5C3; b_r = 16'h1234; b_i2s = 1'b0;

    // Reset state and idle
    repeat (3) tick();
    chk("rst_sclk", sclk_a, 0);
    chk("rst_wsel", wsel_a, 0);
    chk("rst_data", data_a, 0);
    chk("rst_lr", lr_a, 0);
    chk("rst_valid", valid_a, 0);
    chk("rst_ovf", ovf_a, 0);
    rst = 1'b0;
    highs = 0;
    repeat (100) begin
      tick();
      if (sclk_a) highs++;
    end
    chk("idle_sclk_highs", highs, 0);

    // Normal streaming, both framings
    qa.delete(); qb.delete();
    en = 1'b1; c0 = cyc;
    r1 = 0; r2 = 0; wr = 0; wr2 = 0; wf = 0; ps = sclk_a; pw = wsel_a;
    repeat (400) begin
      tick();
      if (sclk_a && !ps) begin
        if (r1 == 0) r1 = cyc; else if (r2 == 0) r2 = cyc;
      end
      if (wsel_a && !pw) begin
        if (wr == 0) wr = cyc; else if (wr2 == 0) wr2 = cyc;
      end
      if (!wsel_a && pw && wf == 0) wf = cyc;
      ps = sclk_a; pw = wsel_a;
    end
    chk("first_sclk_rise", r1 - c0, 2);
    chk("sclk_period", r2 - r1, 4);
    chk("wsel_first_rise", wr - c0, 128);
    chk("wsel_high_time", wf - wr, 128);
    chk("wsel_period", wr2 - wr, 256);
    chk("i2s_xfer_count", qa.size(), 3);
    if (qa.size() >= 2) begin
      chk("i2s_l_cyc", qa[0].cyc - c0, 67);
      chk("i2s_l_data", qa[0].d, 16'hA5C3);
      chk("i2s_l_lr", qa[0].lr, 0);
      chk("i2s_r_cyc", qa[1].cyc - c0, 195);
      chk("i2s_r_data", qa[1].d, 16'h1234);
      chk("i2s_r_lr", qa[1].lr, 1);
    end
    chk("lj_xfer_count", qb.size(), 3);
    if (qb.size() >= 2) begin
      chk("lj_l_cyc", qb[0].cyc - c0, 63);
      chk("lj_l_data", qb[0].d, 16'hA5C3);
      chk("lj_l_lr", qb[0].lr, 0);
      chk("lj_r_cyc", qb[1].cyc - c0, 191);
      chk("lj_r_data", qb[1].d, 16'h1234);
      chk("lj_r_lr", qb[1].lr, 1);
    end

    // LJ receiver fed Philips framing: one-bit misalignment
    en = 1'b0; b_i2s = 1'b1; b_l = 16'h8001; b_r = 16'h8001;
    repeat (4) tick();
    qb.delete();
    en = 1'b1;
    repeat (80) tick();
    chk("lj_misalign_count", qb.size(), 1);
    if (qb.size() >= 1) chk("lj_misalign_data", qb[0].d, 16'h4000);
    b_i2s = 1'b0; b_l = 16'hA5C3; b_r = 16'h1234;

    // Backpressure across three completions
    rst = 1'b1; rdy = 1'b0;
    tick();
    rst = 1'b0; qa.delete(); c0 = cyc;
    run_to(c0 + 193);
    chk("bp_valid_held", valid_a, 1);
    chk("bp_data_first", data_a, 16'hA5C3);
    chk("bp_ovf_before", ovf_a, 0);
    run_to(c0 + 195);
    chk("bp_ovf_after2", ovf_a, 1);
    chk("bp_data_after2", data_a, 16'hA5C3);
    chk("bp_lr_after2", lr_a, 0);
    run_to(c0 + 323);
    chk("bp_data_after3", data_a, 16'hA5C3);
    rdy = 1'b1;
    tick();
    chk("bp_valid_drop", valid_a, 0);
    chk("bp_xfer_count", qa.size(), 1);
    if (qa.size() >= 1) chk("bp_xfer_data", qa[0].d, 16'hA5C3);
    chk("bp_ovf_sticky", ovf_a, 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("bp_ovf_cleared", ovf_a, 0);

    // Ready exactly in the completion cycle; clear colliding with set
    rst = 1'b1; rdy = 1'b0;
    tick();
    rst = 1'b0; qa.delete(); c0 = cyc;
    run_to(c0 + 193);
    chk("same_cyc_held", data_a, 16'hA5C3);
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    chk("same_cyc_valid", valid_a, 1);
    chk("same_cyc_data", data_a, 16'h1234);
    chk("same_cyc_lr", lr_a, 1);
    chk("same_cyc_ovf", ovf_a, 0);
    chk("same_cyc_xfer_count", qa.size(), 1);
    if (qa.size() >= 1) chk("same_cyc_xfer_cyc", qa[0].cyc - c0, 194);
    run_to(c0 + 321);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("set_wins_ovf", ovf_a, 1);
    chk("set_wins_data", data_a, 16'h1234);

    // Enable dropped mid-word, then re-enabled
    rst = 1'b1; rdy = 1'b1;
    tick();
    rst = 1'b0; qa.delete(); c0 = cyc;
    run_to(c0 + 33);
    en = 1'b0;
    tick(); tick();
    chk("dis_sclk", sclk_a, 0);
    chk("dis_wsel", wsel_a, 0);
    repeat (100) tick();
    chk("dis_no_xfer", qa.size(), 0);
    chk("dis_valid", valid_a, 0);
    en = 1'b1; c0 = cyc;
    run_to(c0 + 70);
    chk("reen_count", qa.size(), 1);
    if (qa.size() >= 1) begin
      chk("reen_data", qa[0].d, 16'hA5C3);
      chk("reen_lr", qa[0].lr, 0);
      chk("reen_cyc", qa[0].cyc - c0, 67);
    end

    // Reset pulse mid-word
    en = 1'b0;
    tick();
    en = 1'b1; c0 = cyc;
    run_to(c0 + 33);
    qa.delete();
    rst = 1'b1;
    tick();
    rst = 1'b0; c0 = cyc;
    chk("mid_rst_valid", valid_a, 0);
    chk("mid_rst_sclk", sclk_a, 0);
    run_to(c0 + 70);
    chk("mid_rst_count", qa.size(), 1);
    if (qa.size() >= 1) begin
      chk("mid_rst_data", qa[0].d, 16'hA5C3);
      chk("mid_rst_cyc", qa[0].cyc - c0, 67);
    end
    chk("mid_rst_ovf", ovf_a, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
